// File: rtl/ascii_edge_stream.sv
// Streams one tile row per transfer and emits one ASCII glyph per tile: a luminance glyph, or an edge glyph when enough gradient pixels are found.
// Define ASCII_EDGE_DIAG_EN to classify pixels with both gradients as '/' or '\' instead of folding them into vertical/horizontal.
module ascii_edge_stream #(
    parameter int TILE_WIDTH     = 8,
    parameter int TILE_HEIGHT    = 8,
    parameter int ASCII_LEVELS   = 8,
    parameter int COLORS         = 3,
    parameter int COLOR_DEPTH    = 8,
    parameter int EDGE_THRESHOLD = 32,
    parameter int EDGE_MIN_COUNT = 4,
    localparam int DATA_WIDTH    = COLORS * COLOR_DEPTH,
    localparam int GW            = $clog2(ASCII_LEVELS + 4),
    localparam int CW            = $clog2(TILE_WIDTH * TILE_HEIGHT + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] in_row,
    input  logic                                 in_sof,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [GW-1:0]                        glyph,
    output logic                                 edge_exists,
    output logic [CW-1:0]                        edge_count,
    output logic                                 out_valid,
    input  logic                                 out_ready
);
    localparam int CD = COLOR_DEPTH;
    localparam int PB = $clog2(TILE_WIDTH * TILE_HEIGHT);
    localparam int LB = $clog2(ASCII_LEVELS);
    localparam int RB = $clog2(TILE_HEIGHT);
    localparam int SW = CD + PB;
    localparam logic [RB-1:0] LAST_ROW = RB'(TILE_HEIGHT - 1);
    localparam logic [CD:0]   THR      = (CD+1)'(EDGE_THRESHOLD);

    typedef enum logic [1:0] {ACCUM, RESOLVE, OUT} state_t;

    state_t state_q, state_d;
    logic   load, accept, first;

    logic [RB-1:0]                 row_q, row_d, row_idx;
    logic [TILE_WIDTH-1:0][CD-1:0] lum, prev_q, prev_d;
    logic [TILE_WIDTH-1:0]         pv, ph;
    logic [CW-1:0]                 vcnt_q, vcnt_d, hcnt_q, hcnt_d, v_row, h_row;
`ifdef ASCII_EDGE_DIAG_EN
    logic [TILE_WIDTH-1:0]         ps, pb;
    logic [CW-1:0]                 scnt_q, scnt_d, bcnt_q, bcnt_d, s_row, b_row;
`endif
    logic [SW-1:0]                 sum_q, sum_d, rsum;
    logic [GW-1:0]                 glyph_q, glyph_d;
    logic                          edge_q, edge_d;
    logic [CW-1:0]                 cnt_q, cnt_d, total, best;
    logic [1:0]                    best_code;

    // in_sof forces row 0 regardless of where the partial tile stood
    assign row_idx = in_sof ? '0 : row_q;
    assign first   = (row_idx == '0);
    assign accept  = in_valid & in_ready;

    for (genvar x = 0; x < TILE_WIDTH; x++) begin : g_px
        logic signed [CD:0] gx, gy;
        logic [CD:0]        mx, my;
        logic               ax, ay;

        if (COLORS == 1) begin : g_mono
            assign lum[x] = in_row[x];
        end else begin : g_rgb
            logic [CD+3:0] w;
            assign w = {3'd0, in_row[x][DATA_WIDTH-1 -: CD], 1'b0}
                     + {2'd0, in_row[x][DATA_WIDTH-CD-1 -: CD], 2'b0}
                     + {4'd0, in_row[x][DATA_WIDTH-CD-1 -: CD]}
                     + {4'd0, in_row[x][DATA_WIDTH-2*CD-1 -: CD]};
            assign lum[x] = CD'(w >> 3);
        end

        if (x == TILE_WIDTH - 1) begin : g_last
            assign gx = '0;
        end else begin : g_mid
            assign gx = $signed({1'b0, lum[x+1]}) - $signed({1'b0, lum[x]});
        end
        assign gy = first ? '0 : ($signed({1'b0, lum[x]}) - $signed({1'b0, prev_q[x]}));

        assign mx = gx[CD] ? $unsigned(-gx) : $unsigned(gx);
        assign my = gy[CD] ? $unsigned(-gy) : $unsigned(gy);
        assign ax = (mx > THR);
        assign ay = (my > THR);

`ifdef ASCII_EDGE_DIAG_EN
        assign pv[x] = ax & ~ay;
        assign ph[x] = ay & ~ax;
        assign ps[x] = ax & ay & (gx[CD] == gy[CD]);
        assign pb[x] = ax & ay & (gx[CD] != gy[CD]);
`else
        assign pv[x] = ax & (~ay | (mx >= my));
        assign ph[x] = ay & (~ax | (mx < my));
`endif
    end

    always_comb begin
        v_row = '0;
        h_row = '0;
        rsum  = '0;
`ifdef ASCII_EDGE_DIAG_EN
        s_row = '0;
        b_row = '0;
`endif
        for (int i = 0; i < TILE_WIDTH; i++) begin
            v_row = v_row + CW'(pv[i]);
            h_row = h_row + CW'(ph[i]);
            rsum  = rsum + SW'(lum[i]);
`ifdef ASCII_EDGE_DIAG_EN
            s_row = s_row + CW'(ps[i]);
            b_row = b_row + CW'(pb[i]);
`endif
        end
    end

    // Accumulators restart (rather than add) on the row-0 transfer
    always_comb begin
        row_d  = row_q;
        prev_d = prev_q;
        vcnt_d = vcnt_q;
        hcnt_d = hcnt_q;
        sum_d  = sum_q;
`ifdef ASCII_EDGE_DIAG_EN
        scnt_d = scnt_q;
        bcnt_d = bcnt_q;
`endif
        if (accept) begin
            row_d  = (row_idx == LAST_ROW) ? '0 : row_idx + RB'(1);
            prev_d = lum;
            vcnt_d = (first ? '0 : vcnt_q) + v_row;
            hcnt_d = (first ? '0 : hcnt_q) + h_row;
            sum_d  = (first ? '0 : sum_q) + rsum;
`ifdef ASCII_EDGE_DIAG_EN
            scnt_d = (first ? '0 : scnt_q) + s_row;
            bcnt_d = (first ? '0 : bcnt_q) + b_row;
`endif
        end
    end

    always_comb begin
        best      = vcnt_q;
        best_code = 2'd0;
        total     = vcnt_q + hcnt_q;
        if (hcnt_q > best) begin
            best      = hcnt_q;
            best_code = 2'd1;
        end
`ifdef ASCII_EDGE_DIAG_EN
        total = total + scnt_q + bcnt_q;
        if (scnt_q > best) begin
            best      = scnt_q;
            best_code = 2'd2;
        end
        if (bcnt_q > best) begin
            best      = bcnt_q;
            best_code = 2'd3;
        end
`endif
        cnt_d = total;
        if (total >= CW'(EDGE_MIN_COUNT)) begin
            glyph_d = GW'(ASCII_LEVELS) + GW'(best_code);
            edge_d  = 1'b1;
        end else begin
            glyph_d = GW'(sum_q >> (SW - LB));
            edge_d  = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = enable;
                if (enable && in_valid && row_idx == LAST_ROW)
                    state_d = RESOLVE;
            end
            RESOLVE: begin
                load    = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q   <= '0;
            prev_q  <= '0;
            vcnt_q  <= '0;
            hcnt_q  <= '0;
            sum_q   <= '0;
`ifdef ASCII_EDGE_DIAG_EN
            scnt_q  <= '0;
            bcnt_q  <= '0;
`endif
            glyph_q <= '0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            row_q   <= row_d;
            prev_q  <= prev_d;
            vcnt_q  <= vcnt_d;
            hcnt_q  <= hcnt_d;
            sum_q   <= sum_d;
`ifdef ASCII_EDGE_DIAG_EN
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
`endif
            if (load) begin
                glyph_q <= glyph_d;
                edge_q  <= edge_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    assign glyph       = glyph_q;
    assign edge_exists = edge_q;
    assign edge_count  = cnt_q;
endmodule

// File: tb/tb_ascii_edge_stream.sv
// Directed bench for ascii_edge_stream: a default instance plus an EDGE_THRESHOLD=8 instance sharing the same row stream.
module tb_ascii_edge_stream;
    localparam int TW = 8;
    localparam int TH = 8;
`ifdef ASCII_EDGE_DIAG_EN
    localparam int G_SL = 10;
    localparam int G_BS = 11;
`else
    localparam int G_SL = 8;
    localparam int G_BS = 8;
`endif
    typedef logic [TW-1:0][23:0] row_t;

    logic       clk = 1'b0;
    logic       rst, enable, in_sof, in_valid, out_ready;
    row_t       in_row;
    logic       in_ready0, in_ready1, out_valid0, out_valid1, edge0, edge1;
    logic [3:0] glyph0, glyph1;
    logic [6:0] cnt0, cnt1;
    int         checks = 0;
    int         errors = 0;
    int         results = 0;
    int         r0;
    row_t       tile [TH];

    always #5 clk = ~clk;

    ascii_edge_stream dut (
        .clk(clk), .rst(rst), .enable(enable), .in_row(in_row), .in_sof(in_sof),
        .in_valid(in_valid), .in_ready(in_ready0), .glyph(glyph0), .edge_exists(edge0),
        .edge_count(cnt0), .out_valid(out_valid0), .out_ready(out_ready)
    );

    ascii_edge_stream #(.EDGE_THRESHOLD(8)) dut_t8 (
        .clk(clk), .rst(rst), .enable(enable), .in_row(in_row), .in_sof(in_sof),
        .in_valid(in_valid), .in_ready(in_ready1), .glyph(glyph1), .edge_exists(edge1),
        .edge_count(cnt1), .out_valid(out_valid1), .out_ready(out_ready)
    );

    always @(posedge clk) if (!rst && out_valid0 && out_ready) results <= results + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] gray(input int v);
        return {v[7:0], v[7:0], v[7:0]};
    endfunction

    task automatic fill(input int v);
        for (int r = 0; r < TH; r++) for (int x = 0; x < TW; x++) tile[r][x] = gray(v);
    endtask

    task automatic fill_cols(input int a, input int b);
        for (int r = 0; r < TH; r++) for (int x = 0; x < TW; x++) tile[r][x] = gray(x < 4 ? a : b);
    endtask

    task automatic fill_ramp(input bit rev);
        for (int r = 0; r < TH; r++) for (int x = 0; x < TW; x++)
            tile[r][x] = gray(16 * ((rev ? 7 - x : x) + r));
    endtask

    // Row handshake: inputs change #1 after the edge, transfer on the next edge with in_ready high
    task automatic send_row(input row_t r, input logic sof);
        int n;
        n = 0;
        in_row = r; in_sof = sof; in_valid = 1'b1;
        #1;
        while (!in_ready0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("in_ready_wait", in_ready0, 1);
        tick();
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_rows(input int lo, input int hi, input logic sof_first);
        for (int r = lo; r <= hi; r++) send_row(tile[r], sof_first && r == lo);
    endtask

    // Called right after the last row: one RESOLVE cycle, then the result, then release
    task automatic expect_result(input string tag, input int g, input int e, input int c,
                                 input int g8, input int c8);
        check({tag, "_resolve"}, out_valid0, 0);
        tick();
        check({tag, "_valid"}, out_valid0, 1);
        check({tag, "_glyph"}, glyph0, g);
        check({tag, "_edge"}, edge0, e);
        check({tag, "_count"}, cnt0, c);
        check({tag, "_t8_valid"}, out_valid1, 1);
        check({tag, "_t8_glyph"}, glyph1, g8);
        check({tag, "_t8_count"}, cnt1, c8);
        tick();
        check({tag, "_done"}, out_valid0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; in_sof = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_row = '0;
        repeat (3) tick();
        check("rst_out_valid", out_valid0, 0);
        check("rst_glyph", glyph0, 0);
        check("rst_edge", edge0, 0);
        check("rst_count", cnt0, 0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", in_ready0, 1);

        fill(128);              send_rows(0, 7, 1); expect_result("flat128", 4, 0, 0, 4, 0);
        fill_cols(0, 255);      send_rows(0, 7, 1); expect_result("vstep", 8, 1, 8, 8, 8);
        for (int r = 0; r < TH; r++) for (int x = 0; x < TW; x++) tile[r][x] = gray(r < 4 ? 0 : 255);
                                send_rows(0, 7, 1); expect_result("hstep", 9, 1, 8, 9, 8);
        fill_ramp(1'b0);        send_rows(0, 7, 1); expect_result("ramp_sl", 3, 0, 0, G_SL, 63);
        fill_ramp(1'b1);        send_rows(0, 7, 1); expect_result("ramp_bs", 3, 0, 0, G_BS, 63);
        fill_cols(0, 32);       send_rows(0, 7, 1); expect_result("thr_eq", 0, 0, 0, 8, 8);
        fill_cols(0, 33);       send_rows(0, 7, 1); expect_result("thr_above", 8, 1, 8, 8, 8);

        fill(0); for (int r = 0; r < 3; r++) tile[r][7] = gray(255);
        send_rows(0, 7, 1); expect_result("min_eq", 8, 1, 4, 8, 4);
        fill(0); for (int r = 0; r < 2; r++) tile[r][7] = gray(255);
        send_rows(0, 7, 1); expect_result("min_below", 0, 0, 3, 0, 3);
        fill(0); for (int r = 4; r < TH; r++) for (int x = 4; x < TW; x++) tile[r][x] = gray(255);
        send_rows(0, 7, 1); expect_result("tie_vh", 8, 1, 8, 8, 8);

        for (int r = 0; r < TH; r++) for (int x = 0; x < TW; x++) tile[r][x] = 24'hFF0000;
        send_rows(0, 7, 1); expect_result("lum_red", 1, 0, 0, 1, 0);
        for (int r = 0; r < TH; r++) for (int x = 0; x < TW; x++) tile[r][x] = 24'h00FF00;
        send_rows(0, 7, 1); expect_result("lum_green", 4, 0, 0, 4, 0);

        // enable low mid-tile with a row pending
        fill_cols(0, 255);
        send_rows(0, 2, 1);
        enable = 1'b0; in_row = tile[3]; in_sof = 1'b0; in_valid = 1'b1;
        #1;
        check("en_stall_ready", in_ready0, 0);
        repeat (3) tick();
        check("en_stall_hold", in_ready0, 0);
        check("en_stall_noout", out_valid0, 0);
        enable = 1'b1;
        send_rows(3, 7, 0); expect_result("en_resume", 8, 1, 8, 8, 8);

        // output backpressure
        send_rows(0, 6, 1);
        out_ready = 1'b0;
        send_row(tile[7], 1'b0);
        check("ostall_resolve", out_valid0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("ostall_valid", out_valid0, 1);
            check("ostall_glyph", glyph0, 8);
            check("ostall_edge", edge0, 1);
            check("ostall_count", cnt0, 8);
            check("ostall_in_ready", in_ready0, 0);
            tick();
        end
        out_ready = 1'b1;
        check("ostall_valid6", out_valid0, 1);
        tick();
        check("ostall_release", out_valid0, 0);
        check("ostall_accum", in_ready0, 1);

        // in_sof restarts: after 3 rows, and on what would have been row 7
        r0 = results;
        fill_cols(0, 255); send_rows(0, 2, 1);
        fill(128);         send_rows(0, 7, 1); expect_result("sof_mid", 4, 0, 0, 4, 0);
        fill_cols(0, 255); send_rows(0, 6, 1);
        fill(128);         send_rows(0, 7, 1); expect_result("sof_last", 4, 0, 0, 4, 0);
        check("sof_result_count", results, r0 + 2);

        // reset mid-tile clears outputs and the row counter
        r0 = results;
        fill_cols(0, 255); send_rows(0, 3, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rstmid_valid", out_valid0, 0);
        check("rstmid_glyph", glyph0, 0);
        check("rstmid_edge", edge0, 0);
        check("rstmid_count", cnt0, 0);
        fill(128); send_rows(0, 7, 0); expect_result("rstmid_next", 4, 0, 0, 4, 0);
        check("rstmid_result_count", results, r0 + 1);

        // reset while holding a result
        out_ready = 1'b0;
        fill(200); send_rows(0, 7, 1);
        tick();
        check("rstout_pre_valid", out_valid0, 1);
        check("rstout_pre_glyph", glyph0, 6);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rstout_valid", out_valid0, 0);
        check("rstout_glyph", glyph0, 0);
        check("rstout_in_ready", in_ready0, 1);
        out_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
